// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake, 1-entry skid buffer and IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds a fetch_count output counting IF/ID loads.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruccion,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] skidData;
   logic [31:0] skidPc;
   logic        skidValid;
   logic        accept;
   logic        loadEvent;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign pc_plus4  = pc_out + 32'd4;
   assign accept    = !valid || !stall;

   // Any cycle where IF/ID receives a live word, from memory or from the skid buffer.
   assign loadEvent = !redirect && !flush &&
                      (((state == FETCH) && imem_ack && accept) ||
                       ((state == HOLD) && skidValid && !stall));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instruccion <= 32'h0;
         pc_out      <= 32'h0;
         valid       <= 1'b0;
         skidData    <= 32'h0;
         skidPc      <= 32'h0;
         skidValid   <= 1'b0;
      end else if (redirect) begin
         pc        <= {redirect_pc[31:2], 2'b00};
         valid     <= 1'b0;
         skidValid <= 1'b0;
         state     <= FETCH;
      end else if (flush) begin
         valid     <= 1'b0;
         skidValid <= 1'b0;
         state     <= FETCH;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               if (!stall) valid <= 1'b0;
            end
            FETCH: begin
               if (imem_ack) begin
                  pc <= pc + 32'd4;
                  if (accept) begin
                     instruccion <= imem_data;
                     pc_out      <= pc;
                     valid       <= 1'b1;
                  end else begin
                     // Decode is stalled on a live word, so park this one until it frees up.
                     skidData  <= imem_data;
                     skidPc    <= pc;
                     skidValid <= 1'b1;
                     state     <= HOLD;
                  end
               end else if (!stall) begin
                  valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instruccion <= skidData;
                  pc_out      <= skidPc;
                  valid       <= skidValid;
                  skidValid   <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'h0;
      end else if (loadEvent) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule
